// File: rtl/pipe_pkg.sv
// Shared definitions for the destination-tracking pipeline: default widths,
// forwarding-select encodings and the per-stage control bundle.
package pipe_pkg;

  localparam int AW = 5;
  localparam int DW = 32;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          rf_en;
    logic          load;
  } stage_ctrl_t;

endpackage

// File: rtl/fwd_mux3.sv
// One forwarded operand: picks RF data or a younger in-flight result.
// Purely combinational; the select comes straight from the hazard unit.
module fwd_mux3
  import pipe_pkg::*;
#(
  parameter int DW = pipe_pkg::DW
) (
  input  logic [1:0]    sel,
  input  logic [DW-1:0] rf_d,
  input  logic [DW-1:0] ex_d,
  input  logic [DW-1:0] mem_d,
  input  logic [DW-1:0] wb_d,
  output logic [DW-1:0] y
);

  always_comb begin
    y = rf_d;
    case (sel)
      FWD_EX:  y = ex_d;
      FWD_MEM: y = mem_d;
      FWD_WB:  y = wb_d;
      default: y = rf_d;
    endcase
  end

endmodule

// File: rtl/id_pipe_tracker.sv
// Carries rd / rf_en / load from ID through EX, MEM and WB, builds the three
// forwarded operands and drives the register-file write-back port.
module id_pipe_tracker
  import pipe_pkg::*;
#(
  parameter int AW           = pipe_pkg::AW,
  parameter int DW           = pipe_pkg::DW,
  parameter int CW           = 16,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] id_rd,
  input  logic          id_rf_enable,
  input  logic          id_load_instr,
  input  logic          control_select,
  input  logic [1:0]    mux1_select,
  input  logic [1:0]    mux2_select,
  input  logic [1:0]    mux3_select,
  input  logic [DW-1:0] rf_pa,
  input  logic [DW-1:0] rf_pb,
  input  logic [DW-1:0] rf_pc,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] mem_result,
  output logic [AW-1:0] rd_ex,
  output logic [AW-1:0] rd_mem,
  output logic [AW-1:0] rd_wb,
  output logic          ex_rf_enable,
  output logic          mem_rf_enable,
  output logic          wb_rf_enable,
  output logic          ex_load_instr,
  output logic [DW-1:0] mem_alu_q,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [DW-1:0] op_c,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [CW-1:0] bubble_count
);

  stage_ctrl_t   idex_q, idex_d, exmem_q;
  logic [AW-1:0] rd_wb_q;
  logic          wb_en_q;
  logic [DW-1:0] mem_alu_q_q, wb_data_q;
  logic [CW-1:0] bubble_q, bubble_d;

  // A write to r0 is killed here so nothing downstream ever forwards it.
  always_comb begin
    idex_d = '0;
    if (!control_select) begin
      idex_d.rd    = id_rd;
      idex_d.rf_en = id_rf_enable && !(R0_HARDWIRED && (id_rd == '0));
      idex_d.load  = id_load_instr;
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (control_select && (bubble_q != {CW{1'b1}})) bubble_d = bubble_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      rd_wb_q     <= '0;
      wb_en_q     <= 1'b0;
      mem_alu_q_q <= '0;
      wb_data_q   <= '0;
      bubble_q    <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= idex_q;
      rd_wb_q     <= exmem_q.rd;
      wb_en_q     <= exmem_q.rf_en;
      mem_alu_q_q <= ex_result;
      wb_data_q   <= mem_result;
      bubble_q    <= bubble_d;
    end
  end

  assign rd_ex         = idex_q.rd;
  assign ex_rf_enable  = idex_q.rf_en;
  assign ex_load_instr = idex_q.load;
  assign rd_mem        = exmem_q.rd;
  assign mem_rf_enable = exmem_q.rf_en;
  assign rd_wb         = rd_wb_q;
  assign wb_rf_enable  = wb_en_q;
  assign mem_alu_q     = mem_alu_q_q;
  assign bubble_count  = bubble_q;

  assign rf_we = wb_en_q;
  assign rf_wa = rd_wb_q;
  assign rf_wd = wb_data_q;

  // exmem_q.load is carried for the MEM stage but has no consumer on this block's ports.
  logic unused_mem_load;
  assign unused_mem_load = exmem_q.load;

  fwd_mux3 #(.DW(DW)) u_fwd_a (
    .sel(mux1_select), .rf_d(rf_pa), .ex_d(ex_result), .mem_d(mem_result), .wb_d(wb_data_q), .y(op_a)
  );
  fwd_mux3 #(.DW(DW)) u_fwd_b (
    .sel(mux2_select), .rf_d(rf_pb), .ex_d(ex_result), .mem_d(mem_result), .wb_d(wb_data_q), .y(op_b)
  );
  fwd_mux3 #(.DW(DW)) u_fwd_c (
    .sel(mux3_select), .rf_d(rf_pc), .ex_d(ex_result), .mem_d(mem_result), .wb_d(wb_data_q), .y(op_c)
  );

endmodule

// File: tb/tb_id_pipe_tracker.sv
// Directed bench for id_pipe_tracker (CW=4 so saturation is reachable quickly).
module tb_id_pipe_tracker;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] id_rd = '0;
  logic          id_rf_enable = 1'b0;
  logic          id_load_instr = 1'b0;
  logic          control_select = 1'b0;
  logic [1:0]    mux1_select = 2'd0, mux2_select = 2'd0, mux3_select = 2'd0;
  logic [DW-1:0] rf_pa = 32'hAAAA_0001, rf_pb = 32'hBBBB_0002, rf_pc = 32'hCCCC_0003;
  logic [DW-1:0] ex_result = '0, mem_result = '0;
  logic [AW-1:0] rd_ex, rd_mem, rd_wb, rf_wa;
  logic          ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr, rf_we;
  logic [DW-1:0] mem_alu_q, op_a, op_b, op_c, rf_wd;
  logic [CW-1:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_pipe_tracker #(.AW(AW), .DW(DW), .CW(CW), .R0_HARDWIRED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .id_rd(id_rd), .id_rf_enable(id_rf_enable), .id_load_instr(id_load_instr),
    .control_select(control_select),
    .mux1_select(mux1_select), .mux2_select(mux2_select), .mux3_select(mux3_select),
    .rf_pa(rf_pa), .rf_pb(rf_pb), .rf_pc(rf_pc),
    .ex_result(ex_result), .mem_result(mem_result),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable), .wb_rf_enable(wb_rf_enable),
    .ex_load_instr(ex_load_instr), .mem_alu_q(mem_alu_q),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .bubble_count(bubble_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    id_rd = '0; id_rf_enable = 1'b0; id_load_instr = 1'b0; control_select = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_vec++;
    if ({rd_ex, rd_mem, rd_wb, ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr, rf_we} !== '0) begin
      n_err++; $display("FAIL reset_ctrl: got rd_ex=%0d rd_mem=%0d rd_wb=%0d en=%b%b%b ld=%b we=%b expected all 0",
                        rd_ex, rd_mem, rd_wb, ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr, rf_we);
    end
    n_vec++;
    if (bubble_count !== 4'd0 || mem_alu_q !== '0 || rf_wd !== '0) begin
      n_err++; $display("FAIL reset_data: got bc=%0d alu=%h wd=%h expected 0/0/0", bubble_count, mem_alu_q, rf_wd);
    end
    n_vec++;
    if (op_a !== rf_pa || op_b !== rf_pb || op_c !== rf_pc) begin
      n_err++; $display("FAIL reset_ops: got %h %h %h expected %h %h %h", op_a, op_b, op_c, rf_pa, rf_pb, rf_pc);
    end
    $display("reset: rd_ex=%0d rf_we=%b bc=%0d", rd_ex, rf_we, bubble_count);
    step();
    reset = 1'b0;
  endtask

  task automatic test_pipeline();
    id_rd = 5'd5; id_rf_enable = 1'b1;
    step();
    n_vec++;
    if (rd_ex !== 5'd5 || ex_rf_enable !== 1'b1) begin
      n_err++; $display("FAIL pipe_ex: got rd_ex=%0d en=%b expected 5/1", rd_ex, ex_rf_enable);
    end
    nop(); ex_result = 32'h0000_1234;
    step();
    n_vec++;
    if (rd_mem !== 5'd5 || mem_rf_enable !== 1'b1 || mem_alu_q !== 32'h0000_1234) begin
      n_err++; $display("FAIL pipe_mem: got rd_mem=%0d en=%b alu=%h expected 5/1/00001234", rd_mem, mem_rf_enable, mem_alu_q);
    end
    mem_result = 32'hDEAD_0005;
    step();
    n_vec++;
    if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hDEAD_0005 || rd_wb !== 5'd5) begin
      n_err++; $display("FAIL pipe_wb: got we=%b wa=%0d wd=%h expected 1/5/dead0005", rf_we, rf_wa, rf_wd);
    end
    $display("pipeline: rd5 wb we=%b wa=%0d wd=%h", rf_we, rf_wa, rf_wd);
    step();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL pipe_wb_done: got we=%b expected 0", rf_we);
    end
  endtask

  task automatic test_forward();
    mem_result = 32'h33;
    step();
    ex_result = 32'h11; mem_result = 32'h22;
    mux1_select = 2'b01; mux2_select = 2'b10; mux3_select = 2'b11;
    #1;
    n_vec++;
    if (op_a !== 32'h11 || op_b !== 32'h22 || op_c !== 32'h33) begin
      n_err++; $display("FAIL fwd_sel: got %h %h %h expected 11 22 33", op_a, op_b, op_c);
    end
    mux1_select = 2'b11; mux2_select = 2'b01; mux3_select = 2'b10;
    #1;
    n_vec++;
    if (op_a !== 32'h33 || op_b !== 32'h11 || op_c !== 32'h22) begin
      n_err++; $display("FAIL fwd_rot: got %h %h %h expected 33 11 22", op_a, op_b, op_c);
    end
    mux1_select = 2'b00; mux2_select = 2'b00; mux3_select = 2'b00;
    rf_pa = 32'h0A; rf_pb = 32'h0B; rf_pc = 32'h0C;
    #1;
    n_vec++;
    if (op_a !== 32'h0A || op_b !== 32'h0B || op_c !== 32'h0C) begin
      n_err++; $display("FAIL fwd_rf: got %h %h %h expected 0a 0b 0c", op_a, op_b, op_c);
    end
    $display("forward: a=%h b=%h c=%h", op_a, op_b, op_c);
  endtask

  task automatic test_load_bubble();
    id_rd = 5'd3; id_rf_enable = 1'b1; id_load_instr = 1'b1;
    step();
    n_vec++;
    if (ex_load_instr !== 1'b1 || rd_ex !== 5'd3) begin
      n_err++; $display("FAIL load_ex: got ld=%b rd_ex=%0d expected 1/3", ex_load_instr, rd_ex);
    end
    id_rd = 5'd4; id_load_instr = 1'b0; control_select = 1'b1;
    step();
    n_vec++;
    if (rd_ex !== 5'd0 || ex_rf_enable !== 1'b0 || ex_load_instr !== 1'b0) begin
      n_err++; $display("FAIL bubble_ex: got rd_ex=%0d en=%b ld=%b expected 0/0/0", rd_ex, ex_rf_enable, ex_load_instr);
    end
    n_vec++;
    if (rd_mem !== 5'd3 || mem_rf_enable !== 1'b1 || bubble_count !== 4'd1) begin
      n_err++; $display("FAIL bubble_mem: got rd_mem=%0d en=%b bc=%0d expected 3/1/1", rd_mem, mem_rf_enable, bubble_count);
    end
    control_select = 1'b0;
    step();
    n_vec++;
    if (rd_ex !== 5'd4 || ex_rf_enable !== 1'b1 || bubble_count !== 4'd1) begin
      n_err++; $display("FAIL bubble_resume: got rd_ex=%0d en=%b bc=%0d expected 4/1/1", rd_ex, ex_rf_enable, bubble_count);
    end
    $display("load_bubble: rd_ex=%0d rd_mem=%0d bc=%0d", rd_ex, rd_mem, bubble_count);
  endtask

  task automatic test_r0();
    id_rd = 5'd0; id_rf_enable = 1'b1;
    step();
    n_vec++;
    if (ex_rf_enable !== 1'b0 || rd_ex !== 5'd0) begin
      n_err++; $display("FAIL r0_ex: got en=%b rd_ex=%0d expected 0/0", ex_rf_enable, rd_ex);
    end
    nop();
    step();
    n_vec++;
    if (mem_rf_enable !== 1'b0) begin
      n_err++; $display("FAIL r0_mem: got en=%b expected 0", mem_rf_enable);
    end
    step();
    n_vec++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL r0_wb: got we=%b expected 0", rf_we);
    end
    $display("r0: ex_en=0 wb we=%b", rf_we);
  endtask

  task automatic test_saturation();
    control_select = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n_vec++;
    if (bubble_count !== 4'd6) begin
      n_err++; $display("FAIL bc_count: got %0d expected 6", bubble_count);
    end
    for (int i = 0; i < 15; i++) step();
    n_vec++;
    if (bubble_count !== 4'd15) begin
      n_err++; $display("FAIL bc_sat: got %0d expected 15", bubble_count);
    end
    control_select = 1'b0;
    step();
    n_vec++;
    if (bubble_count !== 4'd15) begin
      n_err++; $display("FAIL bc_hold: got %0d expected 15", bubble_count);
    end
    $display("saturation: bc=%0d", bubble_count);
  endtask

  task automatic test_reset_midrun();
    id_rd = 5'd7; id_rf_enable = 1'b1; mem_result = 32'h7777_7777; ex_result = 32'h5555;
    step();
    n_vec++;
    if (rd_ex !== 5'd7 || ex_rf_enable !== 1'b1) begin
      n_err++; $display("FAIL mid_pre: got rd_ex=%0d en=%b expected 7/1", rd_ex, ex_rf_enable);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if ({rd_ex, rd_mem, rd_wb, ex_rf_enable, mem_rf_enable, wb_rf_enable, ex_load_instr, rf_we} !== '0 ||
        bubble_count !== 4'd0) begin
      n_err++; $display("FAIL mid_reset: got rd_ex=%0d rd_mem=%0d en=%b%b%b we=%b bc=%0d expected all 0",
                        rd_ex, rd_mem, ex_rf_enable, mem_rf_enable, wb_rf_enable, rf_we, bubble_count);
    end
    nop();
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (rf_we !== 1'b0) begin
        n_err++; $display("FAIL mid_no_wb: cycle %0d got we=%b wa=%0d expected 0", i, rf_we, rf_wa);
      end
    end
    $display("reset_midrun: rd_ex=%0d bc=%0d we=%b", rd_ex, bubble_count, rf_we);
  endtask

  initial begin
    test_reset();
    test_pipeline();
    test_forward();
    test_load_bubble();
    test_r0();
    test_saturation();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
